// File: rtl/dlx_multicycle_control_pkg.sv
// dlx_multicycle_control_pkg: opcode constants, state encodings and
// mux-select encodings shared by the DLX control FSM and its datapath.
package dlx_multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQZ   = 6'h04;
    localparam logic [5:0] OP_BNEZ   = 6'h05;
    localparam logic [5:0] OP_IMM_LO = 6'h08;
    localparam logic [5:0] OP_IMM_HI = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_REXEC  = 4'd3,
        S_RWB    = 4'd4,
        S_IEXEC  = 4'd5,
        S_IWB    = 4'd6,
        S_MADDR  = 4'd7,
        S_MRD    = 4'd8,
        S_MWB    = 4'd9,
        S_MWR    = 4'd10,
        S_BRANCH = 4'd11,
        S_JLINK  = 4'd12,
        S_JUMP   = 4'd13,
        S_HALT   = 4'd14
    } state_e;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    localparam logic [1:0] M2R_ALUOUT  = 2'b00;
    localparam logic [1:0] M2R_MEMDATA = 2'b01;
    localparam logic [1:0] M2R_PC      = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/dlx_ctrl_outdec.sv
// dlx_ctrl_outdec: combinational decode of FSM state into datapath strobes.
// Only the branch write-enable looks past the state, at Opcode and Zero.
module dlx_ctrl_outdec
    import dlx_multicycle_control_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  state_e             state,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               zero,
    output ctrl_t              ctrl
);

    logic is_beqz;
    logic is_bnez;

    assign is_beqz = (opcode == OPC_W'(OP_BEQZ));
    assign is_bnez = (opcode == OPC_W'(OP_BNEZ));

    // Per-state strobe table; anything not set stays 0 (RST, HALT, unused codes)
    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_REXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RD;
                ctrl.mem_to_reg = M2R_ALUOUT;
            end
            S_IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_IMM;
            end
            S_IWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = M2R_ALUOUT;
            end
            S_MADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = M2R_MEMDATA;
            end
            S_MWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REGB;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.pc_write_cond = (is_beqz & zero) | (is_bnez & ~zero);
            end
            S_JLINK: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_R31;
                ctrl.mem_to_reg = M2R_PC;
                ctrl.pc_source  = PCSRC_ALU;
                ctrl.alu_src_a  = 1'b0;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dlx_multicycle_control.sv
// dlx_multicycle_control: Moore control FSM for the multicycle DLX datapath.
// Define DLX_ILLEGAL_OP_TRAP_EN to park undecoded opcodes in HALT.
module dlx_multicycle_control
    import dlx_multicycle_control_pkg::*;
#(
    parameter int OPC_W    = 6,
    parameter int RETIRE_W = 32
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [OPC_W-1:0]    Opcode,
    input  logic                Zero,
    input  logic                Overflow,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                ALUSrcA,
    output logic                RegWrite,
    output logic [1:0]          PCSource,
    output logic [1:0]          ALUOp,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          RegDst,
    output logic [1:0]          MemToReg,
    output logic [3:0]          State,
    output logic [RETIRE_W-1:0] Retired,
    output logic                Halted
);

`ifdef DLX_ILLEGAL_OP_TRAP_EN
    localparam state_e S_ILLEGAL = S_HALT;
`else
    localparam state_e S_ILLEGAL = S_FETCH;
`endif

    state_e              state_q;
    state_e              state_d;
    logic [RETIRE_W-1:0] retired_q;
    logic [RETIRE_W-1:0] retired_d;
    ctrl_t               ctrl;

    logic op_rtype;
    logic op_lw;
    logic op_sw;
    logic op_br;
    logic op_j;
    logic op_jal;
    logic op_imm;

    // Overflow never steers control flow
    logic unused_overflow;
    assign unused_overflow = Overflow;

    assign op_rtype = (Opcode == OPC_W'(OP_RTYPE));
    assign op_lw    = (Opcode == OPC_W'(OP_LW));
    assign op_sw    = (Opcode == OPC_W'(OP_SW));
    assign op_br    = (Opcode == OPC_W'(OP_BEQZ)) |
                      (Opcode == OPC_W'(OP_BNEZ));
    assign op_j     = (Opcode == OPC_W'(OP_J));
    assign op_jal   = (Opcode == OPC_W'(OP_JAL));
    assign op_imm   = (Opcode >= OPC_W'(OP_IMM_LO)) &&
                      (Opcode <= OPC_W'(OP_IMM_HI));

    // Next-state: one step per state, opcode dispatch in DECODE and MADDR
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (op_rtype)            state_d = S_REXEC;
                else if (op_lw | op_sw)  state_d = S_MADDR;
                else if (op_br)          state_d = S_BRANCH;
                else if (op_j)           state_d = S_JUMP;
                else if (op_jal)         state_d = S_JLINK;
                else if (op_imm)         state_d = S_IEXEC;
                else                     state_d = S_ILLEGAL;
            end
            S_REXEC:  state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_MADDR:  state_d = op_lw ? S_MRD : S_MWR;
            S_MRD:    state_d = S_MWB;
            S_MWB:    state_d = S_FETCH;
            S_MWR:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JLINK:  state_d = S_JUMP;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_RST;
        endcase
    end

    // Count an instruction each time control returns to FETCH after reset
    always_comb begin
        retired_d = retired_q;
        if ((state_d == S_FETCH) && (state_q != S_RST)) begin
            retired_d = retired_q + RETIRE_W'(1);
        end
    end

    // State and retire counter; reset drops straight back to RST
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_RST;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    dlx_ctrl_outdec #(
        .OPC_W (OPC_W)
    ) u_outdec (
        .state  (state_q),
        .opcode (Opcode),
        .zero   (Zero),
        .ctrl   (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.ior_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign RegWrite    = ctrl.reg_write;
    assign PCSource    = ctrl.pc_source;
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign RegDst      = ctrl.reg_dst;
    assign MemToReg    = ctrl.mem_to_reg;
    assign State       = state_q;
    assign Retired     = retired_q;

`ifdef DLX_ILLEGAL_OP_TRAP_EN
    assign Halted = (state_q == S_HALT);
`else
    assign Halted = 1'b0;
`endif

endmodule

// File: tb/tb_dlx_multicycle_control.sv
// tb_dlx_multicycle_control: scoreboard bench for the DLX control FSM.
// Expected per-cycle output vectors are queued, then popped each negedge.
module tb_dlx_multicycle_control;

    logic        Clock    = 1'b0;
    logic        Reset_n  = 1'b0;
    logic [5:0]  Opcode   = 6'h00;
    logic        Zero     = 1'b0;
    logic        Overflow = 1'b0;
    logic        PCWrite, PCWriteCond, IorD, MemRead;
    logic        MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0]  PCSource, ALUOp, ALUSrcB, RegDst, MemToReg;
    logic [3:0]  State;
    logic [31:0] Retired;
    logic        Halted;

    int total = 0;
    int bad   = 0;
    logic [22:0] exp_q[$];

    always #5 Clock = ~Clock;

    dlx_multicycle_control #(
        .OPC_W    (6),
        .RETIRE_W (32)
    ) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .Opcode      (Opcode),
        .Zero        (Zero),
        .Overflow    (Overflow),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .ALUSrcB     (ALUSrcB),
        .RegDst      (RegDst),
        .MemToReg    (MemToReg),
        .State       (State),
        .Retired     (Retired),
        .Halted      (Halted)
    );

    // {Halted, State, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
    //  IRWrite, ALUSrcA, RegWrite, PCSource, ALUOp, ALUSrcB, RegDst, MemToReg}
    localparam logic [22:0] E_RST    = {1'b0, 4'd0,  8'b0000_0000, 10'b00_00_00_00_00};
    localparam logic [22:0] E_FETCH  = {1'b0, 4'd1,  8'b1001_0100, 10'b00_00_01_00_00};
    localparam logic [22:0] E_DECODE = {1'b0, 4'd2,  8'b0000_0000, 10'b00_00_11_00_00};
    localparam logic [22:0] E_REXEC  = {1'b0, 4'd3,  8'b0000_0010, 10'b00_10_00_00_00};
    localparam logic [22:0] E_RWB    = {1'b0, 4'd4,  8'b0000_0001, 10'b00_00_00_01_00};
    localparam logic [22:0] E_IEXEC  = {1'b0, 4'd5,  8'b0000_0010, 10'b00_11_10_00_00};
    localparam logic [22:0] E_IWB    = {1'b0, 4'd6,  8'b0000_0001, 10'b00_00_00_00_00};
    localparam logic [22:0] E_MADDR  = {1'b0, 4'd7,  8'b0000_0010, 10'b00_00_10_00_00};
    localparam logic [22:0] E_MRD    = {1'b0, 4'd8,  8'b0011_0000, 10'b00_00_00_00_00};
    localparam logic [22:0] E_MWB    = {1'b0, 4'd9,  8'b0000_0001, 10'b00_00_00_00_01};
    localparam logic [22:0] E_MWR    = {1'b0, 4'd10, 8'b0010_1000, 10'b00_00_00_00_00};
    localparam logic [22:0] E_JLINK  = {1'b0, 4'd12, 8'b0000_0001, 10'b00_00_01_10_10};
    localparam logic [22:0] E_JUMP   = {1'b0, 4'd13, 8'b1000_0000, 10'b10_00_00_00_00};
    localparam logic [22:0] E_HALT   = {1'b1, 4'd14, 8'b0000_0000, 10'b00_00_00_00_00};

    function automatic logic [22:0] e_branch(input logic c);
        return {1'b0, 4'd11, 1'b0, c, 6'b000010, 10'b01_01_00_00_00};
    endfunction

    function automatic logic [22:0] obs();
        return {Halted, State, PCWrite, PCWriteCond, IorD, MemRead,
                MemWrite, IRWrite, ALUSrcA, RegWrite, PCSource, ALUOp,
                ALUSrcB, RegDst, MemToReg};
    endfunction

    // Scoreboard consumer: one popped vector per cycle, sampled at negedge
    task automatic drain(input string tag);
        logic [22:0] e;
        int n;
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL %s step%0d: got=%h want=%h", tag, n, obs(), e);
            end
            n++;
            @(negedge Clock);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clock);
        total++;
        if (obs() !== E_RST || Retired !== 32'd0) begin
            bad++;
            $display("FAIL reset_hold: got=%h/%0d want=%h/0", obs(), Retired, E_RST);
        end
        Reset_n = 1'b1;
        total++;
        if (obs() !== E_RST) begin
            bad++;
            $display("FAIL reset_release: got=%h want=%h", obs(), E_RST);
        end
        @(negedge Clock);
        total++;
        if (obs() !== E_FETCH || Retired !== 32'd0) begin
            bad++;
            $display("FAIL reset_fetch: got=%h/%0d want=%h/0", obs(), Retired, E_FETCH);
        end
    endtask

    task automatic test_rtype();
        logic [31:0] r0;
        r0 = Retired;
        Opcode = 6'h00;
        Overflow = 1'b1;
        exp_q.push_back(E_FETCH);
        exp_q.push_back(E_DECODE);
        exp_q.push_back(E_REXEC);
        exp_q.push_back(E_RWB);
        drain("rtype");
        Overflow = 1'b0;
        total++;
        if (Retired !== r0 + 32'd1) begin
            bad++;
            $display("FAIL rtype_retired: got=%0d want=%0d", Retired, r0 + 32'd1);
        end
    endtask

    task automatic test_imm();
        logic [5:0] ops[2] = '{6'h08, 6'h0F};
        logic [31:0] r0;
        for (int i = 0; i < 2; i++) begin
            r0 = Retired;
            Opcode = ops[i];
            exp_q.push_back(E_FETCH);
            exp_q.push_back(E_DECODE);
            exp_q.push_back(E_IEXEC);
            exp_q.push_back(E_IWB);
            drain("imm");
            total++;
            if (Retired !== r0 + 32'd1) begin
                bad++;
                $display("FAIL imm_retired op=%h: got=%0d want=%0d", ops[i], Retired, r0 + 32'd1);
            end
        end
    endtask

    task automatic test_lw_sw();
        logic [31:0] r0;
        r0 = Retired;
        Opcode = 6'h23;
        exp_q.push_back(E_FETCH);
        exp_q.push_back(E_DECODE);
        exp_q.push_back(E_MADDR);
        exp_q.push_back(E_MRD);
        exp_q.push_back(E_MWB);
        drain("lw");
        Opcode = 6'h2B;
        exp_q.push_back(E_FETCH);
        exp_q.push_back(E_DECODE);
        exp_q.push_back(E_MADDR);
        exp_q.push_back(E_MWR);
        drain("sw");
        total++;
        if (Retired !== r0 + 32'd2) begin
            bad++;
            $display("FAIL lwsw_retired: got=%0d want=%0d", Retired, r0 + 32'd2);
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops[4] = '{6'h04, 6'h04, 6'h05, 6'h05};
        logic       zs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       cs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] r0;
        for (int i = 0; i < 4; i++) begin
            r0 = Retired;
            Opcode = ops[i];
            Zero = zs[i];
            exp_q.push_back(E_FETCH);
            exp_q.push_back(E_DECODE);
            exp_q.push_back(e_branch(cs[i]));
            drain("branch");
            total++;
            if (Retired !== r0 + 32'd1) begin
                bad++;
                $display("FAIL branch_retired case%0d: got=%0d want=%0d", i, Retired, r0 + 32'd1);
            end
        end
        Zero = 1'b0;
    endtask

    task automatic test_jumps();
        logic [31:0] r0;
        r0 = Retired;
        Opcode = 6'h03;
        exp_q.push_back(E_FETCH);
        exp_q.push_back(E_DECODE);
        exp_q.push_back(E_JLINK);
        exp_q.push_back(E_JUMP);
        drain("jal");
        Opcode = 6'h02;
        exp_q.push_back(E_FETCH);
        exp_q.push_back(E_DECODE);
        exp_q.push_back(E_JUMP);
        drain("j");
        total++;
        if (Retired !== r0 + 32'd2) begin
            bad++;
            $display("FAIL jump_retired: got=%0d want=%0d", Retired, r0 + 32'd2);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r0;
        r0 = Retired;
        Opcode = 6'h2B;
        exp_q.push_back(E_FETCH);
        exp_q.push_back(E_DECODE);
        exp_q.push_back(E_MADDR);
        exp_q.push_back(E_MWR);
        drain("b2b_sw");
        Opcode = 6'h05;
        Zero = 1'b0;
        exp_q.push_back(E_FETCH);
        exp_q.push_back(E_DECODE);
        exp_q.push_back(e_branch(1'b1));
        drain("b2b_bnez");
        Opcode = 6'h00;
        exp_q.push_back(E_FETCH);
        exp_q.push_back(E_DECODE);
        exp_q.push_back(E_REXEC);
        exp_q.push_back(E_RWB);
        drain("b2b_r");
        total++;
        if (Retired !== r0 + 32'd3) begin
            bad++;
            $display("FAIL b2b_retired: got=%0d want=%0d", Retired, r0 + 32'd3);
        end
    endtask

`ifdef DLX_ILLEGAL_OP_TRAP_EN
    task automatic test_illegal();
        logic [31:0] r0;
        r0 = Retired;
        Opcode = 6'h3F;
        exp_q.push_back(E_FETCH);
        exp_q.push_back(E_DECODE);
        for (int i = 0; i < 10; i++) exp_q.push_back(E_HALT);
        drain("illegal_halt");
        total++;
        if (Retired !== r0) begin
            bad++;
            $display("FAIL halt_retired: got=%0d want=%0d", Retired, r0);
        end
        Reset_n = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;
        @(negedge Clock);
        total++;
        if (obs() !== E_FETCH) begin
            bad++;
            $display("FAIL halt_exit: got=%h want=%h", obs(), E_FETCH);
        end
    endtask
`else
    task automatic test_illegal();
        logic [5:0] ops[3] = '{6'h3F, 6'h01, 6'h10};
        logic [31:0] r0;
        for (int i = 0; i < 3; i++) begin
            r0 = Retired;
            Opcode = ops[i];
            exp_q.push_back(E_FETCH);
            exp_q.push_back(E_DECODE);
            drain("illegal_nop");
            total++;
            if (Retired !== r0 + 32'd1 || obs() !== E_FETCH) begin
                bad++;
                $display("FAIL nop_op=%h: got=%h/%0d want=%h/%0d", ops[i], obs(), Retired, E_FETCH, r0 + 32'd1);
            end
        end
    endtask
`endif

    task automatic test_mid_reset();
        Opcode = 6'h23;
        exp_q.push_back(E_FETCH);
        exp_q.push_back(E_DECODE);
        exp_q.push_back(E_MADDR);
        exp_q.push_back(E_MRD);
        drain("mid_lw");
        #2;
        Reset_n = 1'b0;
        #1;
        total++;
        if (obs() !== E_RST || Retired !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset_async: got=%h/%0d want=%h/0", obs(), Retired, E_RST);
        end
        @(negedge Clock);
        Reset_n = 1'b1;
        total++;
        if (obs() !== E_RST) begin
            bad++;
            $display("FAIL mid_reset_rst: got=%h want=%h", obs(), E_RST);
        end
        @(negedge Clock);
        total++;
        if (obs() !== E_FETCH || Retired !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset_fetch: got=%h/%0d want=%h/0", obs(), Retired, E_FETCH);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_imm();
        test_lw_sw();
        test_branch();
        test_jumps();
        test_back_to_back();
        test_illegal();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule
